camera_clkgen: RTL
==================

CAMERA_CLKGEN -- requirements
Module: camera_clkgen

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, number of output clock channels (1..7).
REQ-002 SHALL provide parameter DIV_W, default 8, divisor width in bits.
REQ-003 SHALL provide parameter DEFAULT_DIV, default 32, reset divisor of every channel (2..2^DIV_W-1).
REQ-004 SHALL provide parameter LOCK_CYCLES, default 16, settle count before lock asserts (>=1).
REQ-005 SHALL provide port clkin, input, 1, sole clock for all logic.
REQ-006 SHALL provide port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL provide port ch_en, input, NUM_CH, per-channel run enable.
REQ-008 SHALL provide port cfg_valid, input, 1, reconfiguration request.
REQ-009 SHALL provide port cfg_ready, output, 1, block accepts a request this cycle.
REQ-010 SHALL provide port cfg_ch, input, 3, target channel index.
REQ-011 SHALL provide port cfg_div, input, DIV_W, new divisor.
REQ-012 SHALL provide port cfg_err, output, 1, one-cycle pulse on rejected request.
REQ-013 SHALL provide port clkout, output, NUM_CH, divided clocks, registered.
REQ-014 SHALL provide port lock, output, 1, all channels stable at programmed ratios.

Function
REQ-015 Each channel SHALL run counter cnt[i] of DIV_W bits, counting 0..div[i]-1 and wrapping to 0.
REQ-016 clkout[i] SHALL be registered from (cnt[i] < hi[i]), so it lags the counter by 1 cycle; hi[i] = floor(div[i]/2).
REQ-017 For an odd divisor, the high phase SHALL be floor(div/2) cycles and the low phase the remainder; for example, div=5 gives 2 high and 3 low.
REQ-018 When ch_en[i]=0, the counter SHALL run to the end of the current period (cnt=div-1), then hold at 0 with clkout[i]=0; no runt pulse is permitted.
REQ-019 When ch_en[i] rises, the channel SHALL restart from cnt=0 on the next cycle.
REQ-020 The controller FSM SHALL have states SETTLE, IDLE and PENDING.
REQ-021 cfg_ready SHALL be 1 only in IDLE, and a request is accepted when cfg_valid && cfg_ready.
REQ-022 An accepted request with cfg_div<2 or cfg_ch>=NUM_CH SHALL pulse cfg_err the next cycle, leave all state unchanged and stay in IDLE.
REQ-023 A valid accepted request SHALL latch ch/div, enter PENDING and drop lock the next cycle.
REQ-024 PENDING SHALL apply the new divisor at the target channel's period boundary (cnt=div-1 wrap), or immediately if that channel is parked disabled; the transition is then to SETTLE.
REQ-025 Other channels SHALL be unaffected by a reconfiguration in progress.
REQ-026 SETTLE SHALL count LOCK_CYCLES cycles, then enter IDLE and set lock=1.
REQ-027 cfg_valid outside IDLE SHALL be ignored, with no error and no queuing.

Reset
REQ-028 On rst_n=0, asynchronously: cnt=0, div=DEFAULT_DIV, clkout=0, lock=0, cfg_ready=0, cfg_err=0, state=SETTLE, settle counter=0.
REQ-029 After release, channels with ch_en=1 SHALL run immediately, and lock/cfg_ready SHALL rise after LOCK_CYCLES cycles.
REQ-030 Reset asserted mid-PENDING or mid-SETTLE SHALL discard the pending request and restore DEFAULT_DIV.

Configuration
REQ-031 With macro CAMERA_CLKGEN_DUTY_EN defined, an extra input cfg_hi (DIV_W) SHALL exist and set hi[i] directly.
REQ-032 Under CAMERA_CLKGEN_DUTY_EN, a request with cfg_hi=0 or cfg_hi>=cfg_div SHALL be rejected via cfg_err.
REQ-033 Without CAMERA_CLKGEN_DUTY_EN, cfg_hi SHALL be absent and hi[i]=floor(div[i]/2) always.

Verification
REQ-034 Reset scenario: NUM_CH=2, DEFAULT_DIV=4, LOCK_CYCLES=8, ch_en=2'b11, release reset -> lock=1 and cfg_ready=1 exactly 8 cycles after release; clkout pattern 1100 repeating on both channels.
REQ-035 Reconfig scenario: cfg_ch=0, cfg_div=6 accepted mid-period -> channel 0 finishes its 4-cycle period, then runs 111000; channel 1 keeps 1100; lock low from accept until 8 cycles after the switch.
REQ-036 Reject scenario: cfg_div=1, then cfg_ch=5 -> cfg_err pulses 1 cycle each; lock stays 1 and divisors are unchanged.
REQ-037 Disable scenario: deassert ch_en[1] at cnt=1 -> channel 1 completes its period, then clkout[1]=0 with no partial pulse; re-enable -> restarts at cnt=0.
REQ-038 Odd divisor scenario: cfg_div=5 -> 2 high, 3 low; under CAMERA_CLKGEN_DUTY_EN, cfg_div=5 with cfg_hi=4 -> 4 high, 1 low; cfg_hi=5 -> cfg_err.
REQ-039 Reset-in-PENDING scenario: rst_n low while PENDING -> after release, divisor=DEFAULT_DIV and the request is lost.

Source files
------------

// File: rtl/camera_clkgen.sv
// rtl/camera_clkgen.sv - multi-channel integer clock divider with glitch-free enable and lock
// Optional macro CAMERA_CLKGEN_DUTY_EN adds cfg_hi to program the high phase directly.
module camera_clkgen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CAMERA_CLKGEN_DUTY_EN
  input  logic [DIV_W-1:0]  cfg_hi,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clkout,
  output logic              lock
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_HI   = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]       NUM_CH_L = 3'(NUM_CH);

  typedef enum logic [1:0] {SETTLE, IDLE, PENDING} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  logic [DIV_W-1:0] phi_q, phi_d;

  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] cnt_d [NUM_CH];
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] div_d [NUM_CH];
  logic [DIV_W-1:0] hi_q  [NUM_CH];
  logic [DIV_W-1:0] hi_d  [NUM_CH];
  logic [NUM_CH-1:0] park_q, park_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] wrap, apply;

  logic [DIV_W-1:0] req_hi;
  logic             req_bad;

  always_comb begin
`ifdef CAMERA_CLKGEN_DUTY_EN
    req_hi  = cfg_hi;
    req_bad = (cfg_div < DIV_W'(2)) || (cfg_ch >= NUM_CH_L) ||
              (cfg_hi == '0) || (cfg_hi >= cfg_div);
`else
    req_hi  = cfg_div >> 1;
    req_bad = (cfg_div < DIV_W'(2)) || (cfg_ch >= NUM_CH_L);
`endif
  end

  // A running channel sits on its period boundary at cnt = div-1.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i] = !park_q[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    err_d    = 1'b0;
    tgt_d    = tgt_q;
    pdiv_d   = pdiv_q;
    phi_d    = phi_q;
    apply    = '0;
    unique case (state_q)
      SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d  = IDLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      IDLE: begin
        if (cfg_valid) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            tgt_d   = cfg_ch;
            pdiv_d  = cfg_div;
            phi_d   = req_hi;
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if ((tgt_q == 3'(i)) && (park_q[i] || wrap[i])) apply[i] = 1'b1;
        end
        if (|apply) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      default: state_d = SETTLE;
    endcase
    lock_d = (state_d == IDLE);
  end

  // Disable takes effect only at the period boundary, so no runt pulse can appear.
  always_comb begin
    park_d = park_q;
    clk_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      hi_d[i]  = hi_q[i];
      clk_d[i] = !park_q[i] && (cnt_q[i] < hi_q[i]);
      if (park_q[i]) begin
        if (ch_en[i]) park_d[i] = 1'b0;
      end else if (wrap[i]) begin
        cnt_d[i]  = '0;
        park_d[i] = !ch_en[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
      if (apply[i]) begin
        div_d[i] = pdiv_q;
        hi_d[i]  = phi_q;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
      tgt_q    <= '0;
      pdiv_q   <= DEF_DIV;
      phi_q    <= DEF_HI;
      park_q   <= '0;
      clk_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DEF_DIV;
        hi_q[i]  <= DEF_HI;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      lock_q   <= lock_d;
      tgt_q    <= tgt_d;
      pdiv_q   <= pdiv_d;
      phi_q    <= phi_d;
      park_q   <= park_d;
      clk_q    <= clk_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
        hi_q[i]  <= hi_d[i];
      end
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign cfg_err   = err_q;
  assign clkout    = clk_q;
  assign lock      = lock_q;

endmodule
